// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq
//  Description : Sequential 32-bit signed divider (radix-2 restoring over
//                magnitudes, MIPS sign fix-up). Quotient drives Lo, remainder
//                drives Hi; one-cycle done pulse and sticky divide-by-zero flag.
//  Revision    : 1.0  initial release
// ============================================================================
module div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        DIV_on,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic        Dzero,
    output logic [31:0] DIV_min,
    output logic [31:0] DIV_max
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [4:0] c_LAST_ITER = 5'd31;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic [31:0] r_rem;        // partial remainder, always below |divisor|
    logic [31:0] r_quo;        // dividend bits shift out, quotient bits shift in
    logic [31:0] r_dvs;        // |divisor|
    logic [4:0]  r_cnt;
    logic        r_sign_q;
    logic        r_sign_r;
    logic        r_dzero;
    logic [31:0] r_div_min;
    logic [31:0] r_div_max;

    logic [31:0] w_abs_dvd;
    logic [31:0] w_abs_dvs;
    logic        w_dvs_zero;
    logic [32:0] w_rem_sh;
    logic [32:0] w_trial;

    // |x| as unsigned; the most negative value maps onto itself, which is the
    // correct unsigned magnitude 0x80000000.
    assign w_abs_dvd  = dividend[31] ? (32'd0 - dividend) : dividend;
    assign w_abs_dvs  = divisor[31]  ? (32'd0 - divisor)  : divisor;
    assign w_dvs_zero = (divisor == 32'd0);

    // 33-bit shifted remainder and trial subtraction; bit 32 of the trial is
    // the borrow, i.e. "trial < 0".
    assign w_rem_sh = {r_rem, r_quo[31]};
    assign w_trial  = w_rem_sh - {1'b0, r_dvs};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode. FIX spans two edges: the first writes the signed
    // results, the second hands off to DONE so done rises one cycle after
    // the result registers change.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (DIV_on) begin
                    w_state_nxt = w_dvs_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == c_LAST_ITER) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                if (r_cnt != 5'd0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, restoring iterations, sign fix-up
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem     <= 32'd0;
            r_quo     <= 32'd0;
            r_dvs     <= 32'd0;
            r_cnt     <= 5'd0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_dzero   <= 1'b0;
            r_div_min <= 32'd0;
            r_div_max <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (DIV_on) begin
                        if (w_dvs_zero) begin
                            // Results are left untouched on divide-by-zero.
                            r_dzero <= 1'b1;
                        end else begin
                            r_dzero  <= 1'b0;
                            r_sign_q <= dividend[31] ^ divisor[31];
                            r_sign_r <= dividend[31];
                            r_quo    <= w_abs_dvd;
                            r_dvs    <= w_abs_dvs;
                            r_rem    <= 32'd0;
                            r_cnt    <= 5'd0;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_trial[32] ? w_rem_sh[31:0] : w_trial[31:0];
                    r_quo <= {r_quo[30:0], ~w_trial[32]};
                    r_cnt <= r_cnt + 5'd1;   // wraps to 0 on the last iteration
                end
                S_FIX: begin
                    if (r_cnt == 5'd0) begin
                        r_div_min <= r_sign_q ? (32'd0 - r_quo) : r_quo;
                        r_div_max <= r_sign_r ? (32'd0 - r_rem) : r_rem;
                    end
                    r_cnt <= r_cnt + 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign Dzero   = r_dzero;
    assign DIV_min = r_div_min;
    assign DIV_max = r_div_max;

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_seq
//  Description : Directed self-checking bench for div_seq with an expected-
//                result queue filled at start and drained at done.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        DIV_on;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        Dzero;
    logic [31:0] DIV_min;
    logic [31:0] DIV_max;

    div_seq dut (
        .clk      (clk),
        .reset    (reset),
        .DIV_on   (DIV_on),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .Dzero    (Dzero),
        .DIV_min  (DIV_min),
        .DIV_max  (DIV_max)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t        r_sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] last_q = 32'd0;
    logic [31:0] last_r = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a start; returns at #1 after the accepting edge with operands scrambled.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sbv;
        longint q;
        longint r;
        dividend = a;
        divisor  = b;
        DIV_on   = 1'b1;
        @(posedge clk);
        #1;
        DIV_on   = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        if (b == 32'd0) begin
            e.q   = last_q;
            e.r   = last_r;
            e.dz  = 1'b1;
            e.lat = 0;
        end else begin
            sa    = longint'($signed(a));
            sbv   = longint'($signed(b));
            q     = sa / sbv;
            r     = sa % sbv;
            e.q   = q[31:0];
            e.r   = r[31:0];
            e.dz  = 1'b0;
            e.lat = 34;
            last_q = e.q;
            last_r = e.r;
        end
        r_sb.push_back(e);
    endtask

    // Wait (bounded) for done, optionally re-pulsing DIV_on at edge inject_at.
    task automatic wait_done(input int inject_at, input logic [31:0] ia, input logic [31:0] ib);
        int   n;
        exp_t e;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            if (inject_at > 0 && n == inject_at - 1) begin
                DIV_on   = 1'b1;
                dividend = ia;
                divisor  = ib;
            end else begin
                DIV_on = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        DIV_on = 1'b0;
        e = r_sb.pop_front();
        check("latency_edges", n, e.lat);
        check("quotient", DIV_min, e.q);
        check("remainder", DIV_max, e.r);
        check("dzero", {31'd0, Dzero}, {31'd0, e.dz});
        check("busy_in_done", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int seen;
        reset    = 1'b1;
        DIV_on   = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_dzero", {31'd0, Dzero}, 32'd0);
        check("rst_min",   DIV_min, 32'd0);
        check("rst_max",   DIV_max, 32'd0);
        reset = 1'b0;

        start(32'd7, 32'd2);                  wait_done(0, 32'd0, 32'd0);
        start(32'hFFFF_FFF9, 32'd2);          wait_done(0, 32'd0, 32'd0);
        start(32'd7, 32'hFFFF_FFFE);          wait_done(0, 32'd0, 32'd0);
        start(32'h8000_0000, 32'hFFFF_FFFF);  wait_done(0, 32'd0, 32'd0);
        start(32'h1234_5678, 32'd1);          wait_done(0, 32'd0, 32'd0);
        start(32'd100, 32'd7);                wait_done(0, 32'd0, 32'd0);
        start(32'd5, 32'd0);                  wait_done(0, 32'd0, 32'd0);
        start(32'd9, 32'd3);                  wait_done(0, 32'd0, 32'd0);

        // Re-pulse while busy must be ignored.
        start(32'd1000, 32'd3);               wait_done(10, 32'd50, 32'd5);

        // Abort with reset at E20.
        start(32'd1000, 32'd3);
        for (int i = 1; i < 20; i++) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy",  {31'd0, busy},  32'd0);
        check("abort_done",  {31'd0, done},  32'd0);
        check("abort_dzero", {31'd0, Dzero}, 32'd0);
        check("abort_min",   DIV_min, 32'd0);
        check("abort_max",   DIV_max, 32'd0);
        reset = 1'b0;
        void'(r_sb.pop_back());
        last_q = 32'd0;
        last_r = 32'd0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        check("no_done_after_abort", seen, 32'd0);

        start(32'd1000, 32'd3);               wait_done(0, 32'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
